// File: rtl/layer_input_packer_pkg.sv
// Shared helpers for the channel packer: output-stage state encoding plus
// elaboration-time sizing functions.
package layer_input_packer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Bits needed to hold values 0..v-1 (0 for v <= 1)
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/layer_input_packer.sv
// Packs Pin-channel input beats into full Nin-channel pixels, presents them
// through a one-deep valid/rdy output register and pulses frame_done per h*w pixels.
module layer_input_packer
    import layer_input_packer_pkg::*;
#(
    parameter int Nin       = 3,
    parameter int Pin       = 1,
    parameter int BIT_WIDTH = 8,
    parameter int h         = 5,
    parameter int w         = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_rdy,
    input  logic [Pin*BIT_WIDTH-1:0] in_data,
    input  logic                     out_rdy,
    output logic                     out_valid,
    output logic [Nin*BIT_WIDTH-1:0] out_data,
    output logic                     frame_done
);

    localparam int TILES = ceil_div(Nin, Pin);
    localparam int NPIX  = h * w;
    localparam int TW    = (clog2(TILES) > 0) ? clog2(TILES) : 1;
    localparam int PW    = (clog2(NPIX) > 0) ? clog2(NPIX) : 1;
    localparam logic [TW-1:0] LAST_TILE = TW'(TILES - 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(NPIX - 1);

    out_state_t                 state_reg, state_next;
    logic [TW-1:0]              tile_cnt_reg;
    logic [PW-1:0]              pix_cnt_reg;
    logic [BIT_WIDTH-1:0]       asm_reg  [Nin];
    logic [BIT_WIDTH-1:0]       asm_next [Nin];
    logic [Nin*BIT_WIDTH-1:0]   merged_data;
    logic [Nin*BIT_WIDTH-1:0]   out_data_reg;
    logic                       frame_done_reg;

    logic final_tile;
    logic accept;
    logic final_accept;
    logic out_hs;
    logic discard_unused;

    // Lanes beyond the last channel on the final tile are simply never routed
    assign discard_unused = ^in_data;

    assign out_valid    = (state_reg == ST_FULL);
    assign out_data     = out_data_reg;
    assign frame_done   = frame_done_reg;
    assign final_tile   = (tile_cnt_reg == LAST_TILE);
    assign in_rdy       = !rst && enable && !(final_tile && out_valid && !out_rdy);
    assign accept       = in_valid && in_rdy;
    assign final_accept = accept && final_tile;
    assign out_hs       = out_valid && out_rdy;

    // Channel gi arrives on lane gi%Pin of tile gi/Pin; final-tile channels
    // bypass the assembly register and merge straight into the output.
    genvar gi;
    generate
        for (gi = 0; gi < Nin; gi++) begin : g_chan
            localparam int TI = gi / Pin;
            localparam int LI = gi % Pin;
            logic [BIT_WIDTH-1:0] lane;
            assign lane = in_data[LI*BIT_WIDTH +: BIT_WIDTH];
            if (TI == TILES - 1) begin : g_final
                assign asm_next[gi] = asm_reg[gi];
                assign merged_data[gi*BIT_WIDTH +: BIT_WIDTH] = lane;
            end else begin : g_body
                assign asm_next[gi] = (accept && tile_cnt_reg == TW'(TI)) ? lane : asm_reg[gi];
                assign merged_data[gi*BIT_WIDTH +: BIT_WIDTH] = asm_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (final_accept) begin
            state_next = ST_FULL;
        end else if (out_hs) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_EMPTY;
            tile_cnt_reg   <= '0;
            pix_cnt_reg    <= '0;
            asm_reg        <= '{default: '0};
            out_data_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            asm_reg        <= asm_next;
            frame_done_reg <= out_hs && (pix_cnt_reg == LAST_PIX);
            if (accept) begin
                tile_cnt_reg <= final_tile ? '0 : tile_cnt_reg + 1'b1;
            end
            if (final_accept) begin
                out_data_reg <= merged_data;
            end
            if (out_hs) begin
                pix_cnt_reg <= (pix_cnt_reg == LAST_PIX) ? '0 : pix_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_input_packer.sv
// Scoreboard bench for layer_input_packer (Nin=3, Pin=2, 2x2 frames): a channel-level
// model pushes expected pixels, an output monitor pops and compares on each presentation.
module tb_layer_input_packer;

    localparam int NIN  = 3;
    localparam int PIN  = 2;
    localparam int BW   = 8;
    localparam int H    = 2;
    localparam int W    = 2;
    localparam int NPIX = H * W;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                in_valid;
    logic                in_rdy;
    logic [PIN*BW-1:0]   in_data;
    logic                out_rdy;
    logic                out_valid;
    logic [NIN*BW-1:0]   out_data;
    logic                frame_done;

    always #5 clk = ~clk;

    layer_input_packer #(
        .Nin       (NIN),
        .Pin       (PIN),
        .BIT_WIDTH (BW),
        .h         (H),
        .w         (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .out_rdy    (out_rdy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    logic [NIN*BW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit iv,
                         input logic [PIN*BW-1:0] d, input bit ordy);
        @(posedge clk);
        #1;
        rst      = r;
        enable   = en;
        in_valid = iv;
        in_data  = d;
        out_rdy  = ordy;
    endtask

    // Input-side reference: channels collected so far and whether a packed pixel is waiting
    initial begin : input_model
        int                ch_cnt;
        bit                pending;
        bit                fin;
        bit                exp_rdy;
        bit                hs;
        logic [NIN*BW-1:0] build;
        ch_cnt  = 0;
        pending = 1'b0;
        build   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("in_rdy_in_reset", in_rdy, 0);
                ch_cnt  = 0;
                pending = 1'b0;
                build   = '0;
                exp_q.delete();
            end else begin
                fin     = (NIN - ch_cnt) <= PIN;
                exp_rdy = enable && !(fin && pending && !out_rdy);
                check("in_rdy", in_rdy, exp_rdy);
                check("out_valid", out_valid, pending);
                hs = pending && out_rdy;
                if (hs) pending = 1'b0;
                if (in_valid && exp_rdy) begin
                    for (int j = 0; j < PIN; j++) begin
                        if (ch_cnt < NIN) begin
                            build[ch_cnt*BW +: BW] = in_data[j*BW +: BW];
                            ch_cnt++;
                        end
                    end
                    if (ch_cnt == NIN) begin
                        exp_q.push_back(build);
                        ch_cnt  = 0;
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    // Output monitor: compares every presented pixel, pops on handshake, tracks frame pulses
    initial begin : output_monitor
        int hs_cnt;
        bit exp_fd;
        hs_cnt = 0;
        exp_fd = 1'b0;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            check("frame_done", frame_done, exp_fd);
            exp_fd = 1'b0;
            if (rst) begin
                hs_cnt = 0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected actual=%0h required=no_pixel time=%0t", out_data, $time);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_rdy) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                        exp_fd = (hs_cnt % NPIX) == 0;
                        $display("pixel %0d data=%h frame_pos=%0d", hs_cnt, out_data, (hs_cnt - 1) % NPIX);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [PIN*BW-1:0] d;
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_rdy  = 1'b0;
        repeat (3) drive(1, 1, 0, '0, 0);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_done", frame_done, 0);

        // Partial final tile: upper lane of the second beat is discarded
        drive(0, 1, 1, 16'h2211, 1);
        drive(0, 1, 1, 16'hFF33, 1);
        drive(0, 1, 0, '0, 1);
        @(negedge clk);
        check("pack_partial", out_data, 24'h332211);
        drive(0, 1, 0, '0, 1);

        // Backpressure: final beat stalls while a pixel is held, then overlaps the handshake
        drive(0, 1, 1, 16'h0201, 0);
        drive(0, 1, 1, 16'h0003, 0);
        drive(0, 1, 1, 16'h0504, 0);
        drive(0, 1, 1, 16'h0006, 0);
        @(negedge clk);
        check("bp_stall_rdy", in_rdy, 0);
        check("bp_held_data", out_data, 24'h030201);
        drive(0, 1, 1, 16'h0006, 0);
        drive(0, 1, 1, 16'h0006, 1);
        drive(0, 1, 0, '0, 1);
        @(negedge clk);
        check("bp_no_bubble_valid", out_valid, 1);
        check("bp_no_bubble_data", out_data, 24'h060504);
        drive(0, 1, 0, '0, 1);

        // Continuous streaming: one pixel per two beats, crossing frame boundaries
        for (int i = 0; i < 16; i++) begin
            d = 16'(i * 16'h0101 + 16'h1020);
            drive(0, 1, 1, d, 1);
        end
        drive(0, 1, 0, '0, 1);

        // Reset mid-pixel discards the partial assembly
        drive(0, 1, 1, 16'h1111, 1);
        drive(1, 1, 1, 16'h2222, 1);
        drive(0, 1, 1, 16'hA2A1, 1);
        drive(0, 1, 1, 16'h00A3, 1);
        drive(0, 1, 0, '0, 1);
        @(negedge clk);
        check("rst_mid_pixel", out_data, 24'hA3A2A1);
        drive(0, 1, 0, '0, 1);

        // enable low blocks input but the held pixel still drains
        drive(0, 1, 1, 16'h0201, 0);
        drive(0, 1, 1, 16'h0003, 0);
        drive(0, 0, 1, 16'h0504, 0);
        drive(0, 0, 1, 16'h0504, 0);
        @(negedge clk);
        check("en_off_rdy", in_rdy, 0);
        check("en_off_held", out_valid, 1);
        drive(0, 0, 1, 16'h0504, 1);
        drive(0, 0, 0, '0, 1);
        @(negedge clk);
        check("en_off_drained", out_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 3) != 0,
                  16'($urandom()),
                  $urandom_range(0, 2) != 0);
        end

        repeat (6) drive(0, 0, 0, '0, 1);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
